// File: rtl/anton_neopixel_stream_ctrl_pkg.sv
// Shared defaults, FSM state type and constant helpers for the neopixel stream controller.
package anton_neopixel_stream_ctrl_pkg;

    localparam int unsigned BUFFER_END_DEFAULT  = 255;
    localparam int unsigned NEO_T0H_DEFAULT     = 8;
    localparam int unsigned NEO_T1H_DEFAULT     = 16;
    localparam int unsigned NEO_TBIT_DEFAULT    = 25;
    localparam int unsigned NEO_TRESET_DEFAULT  = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_GAP
    } neo_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        if (value > 1) begin
            for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
                result++;
            end
        end
        return result;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/anton_neopixel_bit_timer.sv
// Cycle counter for one WS2812 bit period or the reset gap; flags the phase ends.
module anton_neopixel_bit_timer
    import anton_neopixel_stream_ctrl_pkg::*;
#(
    parameter int unsigned T0H    = NEO_T0H_DEFAULT,
    parameter int unsigned T1H    = NEO_T1H_DEFAULT,
    parameter int unsigned TBIT   = NEO_TBIT_DEFAULT,
    parameter int unsigned TRESET = NEO_TRESET_DEFAULT
) (
    input  logic busClk,
    input  logic busResetN,
    input  logic clr_i,
    input  logic bitVal_i,
    input  logic shortBit_i,
    output logic hiDone_o,
    output logic bitDone_o,
    output logic gapDone_o
);

    localparam int unsigned CNT_BITS = clog2(max_u(TBIT, TRESET) + 1);

    localparam logic [CNT_BITS-1:0] T0H_LAST    = CNT_BITS'(T0H - 1);
    localparam logic [CNT_BITS-1:0] T1H_LAST    = CNT_BITS'(T1H - 1);
    localparam logic [CNT_BITS-1:0] TBIT_LAST   = CNT_BITS'(TBIT - 1);
    localparam logic [CNT_BITS-1:0] TBIT_SHORT  = CNT_BITS'(TBIT - 2);
    localparam logic [CNT_BITS-1:0] TRESET_LAST = CNT_BITS'(TRESET - 1);

    logic [CNT_BITS-1:0] cycCnt_q;
    logic [CNT_BITS-1:0] cycCnt_d;

    always_comb begin
        cycCnt_d = clr_i ? '0 : cycCnt_q + 1'b1;
    end

    always_ff @(posedge busClk) begin
        if (!busResetN) begin
            cycCnt_q <= '0;
        end else begin
            cycCnt_q <= cycCnt_d;
        end
    end

    // Short bit ends one cycle early so the following LOAD cycle completes the low phase.
    assign hiDone_o  = (cycCnt_q == (bitVal_i ? T1H_LAST : T0H_LAST));
    assign bitDone_o = (cycCnt_q == (shortBit_i ? TBIT_SHORT : TBIT_LAST));
    assign gapDone_o = (cycCnt_q == TRESET_LAST);

endmodule

// File: rtl/anton_neopixel_stream_ctrl.sv
// Frame sequencer: walks the pixel buffer, serialises bytes MSB-first as WS2812 pulses, then holds the reset gap.
module anton_neopixel_stream_ctrl
    import anton_neopixel_stream_ctrl_pkg::*;
#(
    parameter int unsigned BUFFER_END  = BUFFER_END_DEFAULT,
    parameter int unsigned T0H         = NEO_T0H_DEFAULT,
    parameter int unsigned T1H         = NEO_T1H_DEFAULT,
    parameter int unsigned TBIT        = NEO_TBIT_DEFAULT,
    parameter int unsigned TRESET      = NEO_TRESET_DEFAULT,
    localparam int unsigned BUFFER_BITS = clog2(BUFFER_END + 1)
) (
    input  logic                   busClk,
    input  logic                   busResetN,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLimit,
    input  logic                   regCtrl32bit,
    input  logic [12:0]            regMax,
    output logic [BUFFER_BITS-1:0] pixelAddr,
    input  logic [7:0]             pixelByte,
    output logic                   neoData,
    output logic                   busy,
    output logic                   streamSyncOf
);

    neo_state_e             state_q, state_d;
    logic [BUFFER_BITS-1:0] addr_q, addr_d;
    logic [BUFFER_BITS-1:0] lastIdx_q, lastIdx_d;
    logic                   mode32_q, mode32_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bitCnt_q, bitCnt_d;
    logic                   neo_q, busy_q;

    logic [31:0]            regMaxW;
    logic [BUFFER_BITS-1:0] frameLast;
    logic [BUFFER_BITS:0]   nextAddr;
    logic                   lastByte;
    logic                   shortBit;
    logic                   timerClr;
    logic                   hiDone, bitDone, gapDone;

    assign regMaxW   = {19'd0, regMax};
    assign frameLast = (regCtrlLimit && (regMaxW < BUFFER_END)) ? BUFFER_BITS'(regMaxW)
                                                                : BUFFER_BITS'(BUFFER_END);

    // One extra bit of width so stepping past the buffer end is visible to the compare.
    always_comb begin
        nextAddr = {1'b0, addr_q} + 1'b1;
        if (mode32_q && (nextAddr[1:0] == 2'b11)) begin
            nextAddr = nextAddr + 1'b1;
        end
    end

    assign lastByte = (nextAddr > {1'b0, lastIdx_q});
    assign shortBit = (bitCnt_q == 3'd0) && !lastByte;

    anton_neopixel_bit_timer #(
        .T0H    (T0H),
        .T1H    (T1H),
        .TBIT   (TBIT),
        .TRESET (TRESET)
    ) u_bit_timer (
        .busClk     (busClk),
        .busResetN  (busResetN),
        .clr_i      (timerClr),
        .bitVal_i   (shift_q[7]),
        .shortBit_i (shortBit),
        .hiDone_o   (hiDone),
        .bitDone_o  (bitDone),
        .gapDone_o  (gapDone)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lastIdx_d    = lastIdx_q;
        mode32_d     = mode32_q;
        shift_d      = shift_q;
        bitCnt_d     = bitCnt_q;
        timerClr     = 1'b0;
        streamSyncOf = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timerClr = 1'b1;
                if (regCtrlRun) begin
                    state_d   = ST_LOAD;
                    addr_d    = '0;
                    lastIdx_d = frameLast;
                    mode32_d  = regCtrl32bit;
                end
            end
            ST_LOAD: begin
                timerClr = 1'b1;
                shift_d  = pixelByte;
                bitCnt_d = 3'd7;
                state_d  = ST_BIT_HI;
            end
            ST_BIT_HI: begin
                if (hiDone) begin
                    state_d = ST_BIT_LO;
                end
            end
            ST_BIT_LO: begin
                if (bitDone) begin
                    timerClr = 1'b1;
                    if (bitCnt_q != 3'd0) begin
                        bitCnt_d = bitCnt_q - 3'd1;
                        shift_d  = {shift_q[6:0], 1'b0};
                        state_d  = ST_BIT_HI;
                    end else if (lastByte) begin
                        state_d = ST_GAP;
                    end else begin
                        addr_d  = nextAddr[BUFFER_BITS-1:0];
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gapDone) begin
                    streamSyncOf = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge busClk) begin
        if (!busResetN) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            lastIdx_q <= '0;
            mode32_q  <= 1'b0;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            neo_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lastIdx_q <= lastIdx_d;
            mode32_q  <= mode32_d;
            shift_q   <= shift_d;
            bitCnt_q  <= bitCnt_d;
            neo_q     <= (state_d == ST_BIT_HI);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign pixelAddr = addr_q;
    assign neoData   = neo_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_anton_neopixel_stream_ctrl.sv
// Directed bench for anton_neopixel_stream_ctrl with short timing (T0H=2, T1H=4, TBIT=6, TRESET=10, 8-byte buffer).
module tb_anton_neopixel_stream_ctrl;

    logic        busClk = 1'b0;
    logic        busResetN;
    logic        regCtrlRun;
    logic        regCtrlLimit;
    logic        regCtrl32bit;
    logic [12:0] regMax;
    logic [2:0]  pixelAddr;
    logic [7:0]  pixelByte;
    logic        neoData;
    logic        busy;
    logic        streamSyncOf;

    logic [7:0]  mem [8];
    assign pixelByte = mem[pixelAddr];

    int checks   = 0;
    int failures = 0;

    bit wave[$];
    int busyCycles;
    int highCycles;
    int syncIdx;
    bit addrSeen [8];

    always #5 busClk = ~busClk;

    anton_neopixel_stream_ctrl #(
        .BUFFER_END (7),
        .T0H        (2),
        .T1H        (4),
        .TBIT       (6),
        .TRESET     (10)
    ) dut (
        .busClk       (busClk),
        .busResetN    (busResetN),
        .regCtrlRun   (regCtrlRun),
        .regCtrlLimit (regCtrlLimit),
        .regCtrl32bit (regCtrl32bit),
        .regMax       (regMax),
        .pixelAddr    (pixelAddr),
        .pixelByte    (pixelByte),
        .neoData      (neoData),
        .busy         (busy),
        .streamSyncOf (streamSyncOf)
    );

    // Pulses (or holds) run and records one sample per cycle until streamSyncOf or the budget expires.
    task automatic capture(input bit hold, input logic [12:0] maxAfter, input int budget);
        wave.delete();
        busyCycles = 0;
        highCycles = 0;
        syncIdx    = -1;
        for (int i = 0; i < 8; i++) addrSeen[i] = 1'b0;
        @(negedge busClk);
        regCtrlRun = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge busClk);
            if (c == 0) begin
                if (!hold) regCtrlRun = 1'b0;
                regMax = maxAfter;
            end
            wave.push_back(neoData);
            if (neoData) highCycles++;
            if (busy) begin
                busyCycles++;
                addrSeen[pixelAddr] = 1'b1;
            end
            if (streamSyncOf) begin
                syncIdx = c;
                break;
            end
        end
    endtask

    task automatic load_mem_mixed();
        mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'h0F; mem[3] = 8'hAA;
        mem[4] = 8'h01; mem[5] = 8'h80; mem[6] = 8'h3C; mem[7] = 8'h55;
    endtask

    task automatic test_reset();
        busResetN = 1'b0;
        regCtrlRun = 1'b0; regCtrlLimit = 1'b0; regCtrl32bit = 1'b0; regMax = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (3) @(negedge busClk);
        checks++;
        if ({neoData, busy, streamSyncOf, pixelAddr} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got neo=%b busy=%b sync=%b addr=%0d exp all 0",
                     neoData, busy, streamSyncOf, pixelAddr);
        end
        busResetN = 1'b1;
        @(negedge busClk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_single_byte();
        logic [47:0] got;
        logic [47:0] exp;
        int gapHigh;
        exp = 48'b111100_110000_111100_110000_110000_111100_110000_111100;
        mem[0] = 8'hA5;
        regCtrlLimit = 1'b1; regCtrl32bit = 1'b0; regMax = 13'd0;
        capture(1'b0, 13'd0, 200);
        got = '0;
        for (int i = 0; i < 48; i++) got[47-i] = (1 + i < wave.size()) ? wave[1+i] : 1'bx;
        gapHigh = 0;
        for (int i = 49; i < wave.size(); i++) if (wave[i]) gapHigh++;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL t1_wave got=%h exp=%h", got, exp);
        end
        checks++;
        if (wave[0] !== 1'b0) begin
            failures++;
            $display("FAIL t1_load_low got=%b exp=0", wave[0]);
        end
        checks++;
        if (syncIdx !== 58) begin
            failures++;
            $display("FAIL t1_sync_idx got=%0d exp=58", syncIdx);
        end
        checks++;
        if (gapHigh !== 0) begin
            failures++;
            $display("FAIL t1_gap_low high_cycles got=%0d exp=0", gapHigh);
        end
        checks++;
        if (busyCycles !== 59) begin
            failures++;
            $display("FAIL t1_busy_len got=%0d exp=59", busyCycles);
        end
        @(negedge busClk);
        checks++;
        if ({busy, streamSyncOf, neoData} !== 3'b000) begin
            failures++;
            $display("FAIL t1_after_sync got busy=%b sync=%b neo=%b exp 000", busy, streamSyncOf, neoData);
        end
    endtask

    task automatic test_32bit_skip();
        load_mem_mixed();
        regCtrlLimit = 1'b0; regCtrl32bit = 1'b1; regMax = 13'd0;
        capture(1'b0, 13'd0, 600);
        checks++;
        if (syncIdx !== 298) begin
            failures++;
            $display("FAIL t2_sync_idx got=%0d exp=298", syncIdx);
        end
        checks++;
        if (highCycles !== 132) begin
            failures++;
            $display("FAIL t2_high_cycles got=%0d exp=132", highCycles);
        end
        checks++;
        if ({addrSeen[3], addrSeen[7], addrSeen[6]} !== 3'b001) begin
            failures++;
            $display("FAIL t2_addr_skip got seen3=%b seen7=%b seen6=%b exp 0 0 1",
                     addrSeen[3], addrSeen[7], addrSeen[6]);
        end
        checks++;
        if (busyCycles !== 299) begin
            failures++;
            $display("FAIL t2_busy_len got=%0d exp=299", busyCycles);
        end
    endtask

    task automatic test_limit_clamp();
        load_mem_mixed();
        regCtrlLimit = 1'b1; regCtrl32bit = 1'b0; regMax = 13'd100;
        capture(1'b0, 13'd100, 800);
        checks++;
        if (busyCycles !== 395) begin
            failures++;
            $display("FAIL t3_busy_len got=%0d exp=395", busyCycles);
        end
        checks++;
        if (highCycles !== 180) begin
            failures++;
            $display("FAIL t3_high_cycles got=%0d exp=180", highCycles);
        end
        checks++;
        if (addrSeen[7] !== 1'b1) begin
            failures++;
            $display("FAIL t3_last_addr seen7 got=%b exp=1", addrSeen[7]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        mem[0] = 8'hA5;
        regCtrlLimit = 1'b1; regCtrl32bit = 1'b0; regMax = 13'd0;
        capture(1'b1, 13'd0, 200);
        checks++;
        if (syncIdx !== 58) begin
            failures++;
            $display("FAIL t4_first_sync got=%0d exp=58", syncIdx);
        end
        @(negedge busClk);
        checks++;
        if ({busy, neoData} !== 2'b00) begin
            failures++;
            $display("FAIL t4_idle_cycle got busy=%b neo=%b exp 00", busy, neoData);
        end
        @(negedge busClk);
        checks++;
        if ({busy, neoData} !== 2'b10) begin
            failures++;
            $display("FAIL t4_load_cycle got busy=%b neo=%b exp 10", busy, neoData);
        end
        @(negedge busClk);
        regCtrlRun = 1'b0;
        checks++;
        if (neoData !== 1'b1) begin
            failures++;
            $display("FAIL t4_first_rise got=%b exp=1", neoData);
        end
        n = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge busClk);
            if (streamSyncOf) begin
                n = c;
                break;
            end
        end
        checks++;
        if (n !== 57) begin
            failures++;
            $display("FAIL t4_second_sync got=%0d exp=57", n);
        end
        repeat (2) @(negedge busClk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL t4_stays_idle busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        int syncSeen;
        logic [47:0] got;
        load_mem_mixed();
        regCtrlLimit = 1'b0; regCtrl32bit = 1'b0; regMax = 13'd0;
        @(negedge busClk);
        regCtrlRun = 1'b1;
        @(negedge busClk);
        regCtrlRun = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge busClk);
            if (pixelAddr == 3'd3 && neoData) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            failures++;
            $display("FAIL t5_reach_byte3 got=%b exp=1", found);
        end
        busResetN = 1'b0;
        @(negedge busClk);
        busResetN = 1'b1;
        checks++;
        if ({neoData, busy, streamSyncOf, pixelAddr} !== 6'b0) begin
            failures++;
            $display("FAIL t5_abort got neo=%b busy=%b sync=%b addr=%0d exp all 0",
                     neoData, busy, streamSyncOf, pixelAddr);
        end
        syncSeen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge busClk);
            if (streamSyncOf || busy) syncSeen++;
        end
        checks++;
        if (syncSeen !== 0) begin
            failures++;
            $display("FAIL t5_no_sync_after_abort active_cycles got=%0d exp=0", syncSeen);
        end
        regCtrlLimit = 1'b1; regMax = 13'd0;
        capture(1'b0, 13'd0, 200);
        got = '0;
        for (int i = 0; i < 48; i++) got[47-i] = (1 + i < wave.size()) ? wave[1+i] : 1'bx;
        checks++;
        if (got !== 48'hF3CF3CF3CF3C) begin
            failures++;
            $display("FAIL t5_restart_byte0 got=%h exp=%h", got, 48'hF3CF3CF3CF3C);
        end
        checks++;
        if (syncIdx !== 58) begin
            failures++;
            $display("FAIL t5_restart_sync got=%0d exp=58", syncIdx);
        end
    endtask

    task automatic test_regmax_change();
        load_mem_mixed();
        regCtrlLimit = 1'b1; regCtrl32bit = 1'b0; regMax = 13'd1;
        capture(1'b0, 13'd4, 600);
        checks++;
        if (syncIdx !== 106) begin
            failures++;
            $display("FAIL t6_frozen_len got=%0d exp=106", syncIdx);
        end
        checks++;
        if (addrSeen[2] !== 1'b0) begin
            failures++;
            $display("FAIL t6_no_byte2 seen2 got=%b exp=0", addrSeen[2]);
        end
        capture(1'b0, 13'd4, 600);
        checks++;
        if (syncIdx !== 250) begin
            failures++;
            $display("FAIL t6_new_len got=%0d exp=250", syncIdx);
        end
        checks++;
        if ({addrSeen[4], addrSeen[5]} !== 2'b10) begin
            failures++;
            $display("FAIL t6_new_last got seen4=%b seen5=%b exp 1 0", addrSeen[4], addrSeen[5]);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_32bit_skip();
        test_limit_clamp();
        test_back_to_back();
        test_reset_mid_frame();
        test_regmax_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
